// File: rtl/cmdfifo_master_pkg.sv
// Shared definitions for the command-FIFO master: FSM states, header
// layout and error status codes.
package cmdfifo_master_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    LEN    = 3'd2,
    WDATA  = 3'd3,
    RDATA  = 3'd4,
    FINISH = 3'd5
  } state_t;

  // Header byte layout: {read_flag, 1'b0, addr[5:0]}
  localparam int READ_FLAG_BIT = 7;
  localparam int ADDR_MSB      = 5;

  // Status reported on the error output
  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_FAIL = 1'b1;

  function automatic logic [7:0] make_header(input logic write, input logic [ADDR_MSB:0] addr);
    logic [7:0] h;
    h = 8'h00;
    h[READ_FLAG_BIT] = ~write;
    h[ADDR_MSB:0]    = addr;
    return h;
  endfunction

endpackage

// File: rtl/cmdfifo_master_watchdog.sv
// Read-response watchdog: counts consecutive cycles spent waiting on an
// empty responder FIFO and flags expiry on the TIMEOUT_CYCLES-th one.
module cmdfifo_master_watchdog
  import cmdfifo_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic empty,
  input  logic pop,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_reg;

  // Count empty cycles while waiting; any pop or leaving the read phase restarts
  always_ff @(posedge clk) begin
    if (reset || !active || pop) begin
      count_reg <= '0;
    end else if (empty && !expired) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign expired = active && empty && (count_reg == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cmdfifo_master.sv
// Command-FIFO master: serializes one register transaction into header,
// length and payload bytes toward the responder RX FIFO and collects read
// response bytes from the responder TX FIFO.
// Optional feature: define CMDMASTER_TIMEOUT_EN to compile in the
// read-response watchdog (cmdfifo_master_watchdog).
module cmdfifo_master
  import cmdfifo_master_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_len,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       done,
  output logic       error,
  output logic [7:0] tx_byte,
  output logic       tx_wr,
  input  logic       tx_full,
  input  logic [7:0] rx_byte,
  output logic       rx_rd,
  input  logic       rx_empty
);

  state_t     state_reg, state_next;
  logic       write_reg, write_next;
  logic [5:0] addr_reg, addr_next;
  logic [7:0] remaining_reg, remaining_next;
  logic [7:0] tx_byte_reg, tx_byte_next;
  logic       tx_wr_reg, tx_wr_next;
  logic       wr_ready_reg, wr_ready_next;
  logic       rx_rd_reg, rx_rd_next;
  logic       done_reg, done_next;
  logic       error_reg, error_next;
  logic       req_ready_reg, req_ready_next;
  logic [7:0] rd_data_reg;
  logic       rd_valid_reg;
  logic       len_ok;
  logic       timeout_hit;

  assign len_ok = (req_len != 8'd0) && (req_len <= 8'(MAX_LEN));

`ifdef CMDMASTER_TIMEOUT_EN
  cmdfifo_master_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (state_reg == RDATA),
    .empty  (rx_empty),
    .pop    (rx_rd_reg),
    .expired(timeout_hit)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit = 1'b0;
`endif

  // State and registered output strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      write_reg     <= 1'b0;
      addr_reg      <= 6'd0;
      remaining_reg <= 8'd0;
      tx_byte_reg   <= 8'd0;
      tx_wr_reg     <= 1'b0;
      wr_ready_reg  <= 1'b0;
      rx_rd_reg     <= 1'b0;
      done_reg      <= 1'b0;
      error_reg     <= ERR_NONE;
      req_ready_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      tx_byte_reg   <= tx_byte_next;
      tx_wr_reg     <= tx_wr_next;
      wr_ready_reg  <= wr_ready_next;
      rx_rd_reg     <= rx_rd_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      req_ready_reg <= req_ready_next;
    end
  end

  // Next-state and next-strobe decisions; each strobe is decided from the
  // FIFO flags of the current cycle and becomes visible in the next one.
  // On acceptance the header is issued directly when the FIFO has room;
  // HDR only holds the transaction while the FIFO is full.
  always_comb begin
    state_next     = state_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    tx_byte_next   = tx_byte_reg;
    tx_wr_next     = 1'b0;
    wr_ready_next  = 1'b0;
    rx_rd_next     = 1'b0;
    done_next      = 1'b0;
    error_next     = error_reg;
    unique case (state_reg)
      IDLE: begin
        if (req_valid && req_ready_reg) begin
          if (len_ok) begin
            write_next     = req_write;
            addr_next      = req_addr;
            remaining_next = req_len;
            error_next     = ERR_NONE;
            if (!tx_full) begin
              tx_byte_next = make_header(req_write, req_addr);
              tx_wr_next   = 1'b1;
              state_next   = LEN;
            end else begin
              state_next = HDR;
            end
          end else begin
            error_next = ERR_FAIL;
            done_next  = 1'b1;
          end
        end
      end
      HDR: begin
        if (!tx_full) begin
          tx_byte_next = make_header(write_reg, addr_reg);
          tx_wr_next   = 1'b1;
          state_next   = LEN;
        end
      end
      LEN: begin
        if (!tx_full) begin
          tx_byte_next = remaining_reg;
          tx_wr_next   = 1'b1;
          state_next   = write_reg ? WDATA : RDATA;
        end
      end
      WDATA: begin
        if (wr_valid && !tx_full) begin
          tx_byte_next   = wr_data;
          tx_wr_next     = 1'b1;
          wr_ready_next  = 1'b1;
          remaining_next = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) state_next = FINISH;
        end
      end
      RDATA: begin
        // rx_empty seen during a pop cycle predates that pop, so never
        // issue a pop in the cycle right after another one.
        if (!rx_empty && !rx_rd_reg) begin
          rx_rd_next     = 1'b1;
          remaining_next = remaining_reg - 8'd1;
          if (remaining_reg == 8'd1) state_next = FINISH;
        end else if (timeout_hit) begin
          error_next = ERR_FAIL;
          state_next = FINISH;
        end
      end
      FINISH: begin
        // Let the final pop's response byte come out before signalling done
        if (!rx_rd_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready comes back one cycle after the done pulse of a real transaction
  assign req_ready_next = (state_next == IDLE) && (state_reg != FINISH);

  // Capture the popped head byte; rd_valid trails rx_rd by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= 8'd0;
    end else begin
      rd_valid_reg <= rx_rd_reg;
      if (rx_rd_reg) rd_data_reg <= rx_byte;
    end
  end

  assign req_ready = req_ready_reg;
  assign wr_ready  = wr_ready_reg;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign tx_byte   = tx_byte_reg;
  assign tx_wr     = tx_wr_reg;
  assign rx_rd     = rx_rd_reg;

endmodule

// File: tb/tb_cmdfifo_master.sv
// Bench for cmdfifo_master: table vectors, randomized transactions against a
// byte-stream model, and hand sequences for reset and read starvation.
// Honours CMDMASTER_TIMEOUT_EN (watchdog limit then set to 16 cycles).
module tb_cmdfifo_master;
  import cmdfifo_master_pkg::*;

  localparam int MAX_LEN = 8;
`ifdef CMDMASTER_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65535;
`endif

  logic       clk, reset;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_len, wr_data, rd_data, tx_byte, rx_byte;
  logic       wr_valid, wr_ready, rd_valid, done, error;
  logic       tx_wr, tx_full, rx_rd, rx_empty;

  cmdfifo_master #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .error(error),
    .tx_byte(tx_byte), .tx_wr(tx_wr), .tx_full(tx_full), .rx_byte(rx_byte),
    .rx_rd(rx_rd), .rx_empty(rx_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] wq[$], rxq[$], txq[$], rdq[$];
  int txc[$];
  int widx = 0, full_from = 0, full_to = 0;
  bit gap_en = 1'b0, pop_flag = 1'b0, prev_full = 1'b0, prev_rxrd = 1'b0;
  int done_cnt = 0, done_cyc = -10, viol = 0, underflow = 0, last_pop_cyc = 0;
  bit done_err, done_rdy, rdy_after;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Responder FIFOs and payload source, updated just after each edge
  always @(posedge clk) begin
    #1;
    if (pop_flag) begin
      if (rxq.size() == 0) underflow++;
      else rxq.delete(0);
    end
    if (wr_ready) widx++;
    rx_empty = (rxq.size() == 0);
    rx_byte  = rx_empty ? 8'h00 : rxq[0];
    wr_valid = (widx < wq.size()) && (!gap_en || ($urandom_range(0, 3) != 0));
    wr_data  = (widx < wq.size()) ? wq[widx] : 8'h00;
    tx_full  = (cyc >= full_from) && (cyc < full_to);
  end

  // Monitor: collect bytes and check strobe rules mid-cycle
  always @(negedge clk) begin
    pop_flag = rx_rd;
    if (rx_rd) last_pop_cyc = cyc;
    if (tx_wr) begin
      txq.push_back(tx_byte);
      txc.push_back(cyc);
      if (prev_full) viol++;
    end
    if (wr_ready && !tx_wr) viol++;
    if (rd_valid) begin
      rdq.push_back(rd_data);
      if (!prev_rxrd) viol++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = error;
      done_rdy = req_ready;
    end
    if (cyc == done_cyc + 1) rdy_after = req_ready;
    prev_full = tx_full;
    prev_rxrd = rx_rd;
  end

  typedef struct {
    bit w; bit [5:0] addr; bit [7:0] len; bit [7:0] d0;
    int soff; int slen; bit gap; bit exp_err; int exp_ntx; bit tchk;
  } vec_t;

  // Prepare queues, raise one request, return the acceptance cycle
  task automatic start_txn(input bit w, input bit [5:0] ad, input bit [7:0] ln,
                           input int nsup, input bit [7:0] d0, input bit rnd,
                           input int soff, input int slen, input bit gap,
                           output int a, output logic [7:0] pl[$]);
    int k;
    logic [7:0] b;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (!req_ready) chk("ready_wait", 0, 1);
    txq.delete(); txc.delete(); rdq.delete(); wq.delete(); rxq.delete(); pl.delete();
    widx = 0; done_cnt = 0; viol = 0; gap_en = gap; done_cyc = -10;
    for (int i = 0; i < nsup; i++) begin
      b = rnd ? 8'($urandom) : d0 + 8'(i * 17);
      pl.push_back(b);
      if (w) wq.push_back(b); else rxq.push_back(b);
    end
    a = cyc + 1;
    full_from = a + soff;
    full_to = a + soff + slen;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = ad; req_len = ln;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == 0 && k < budget) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
  endtask

  // Full transaction with checks against the model byte stream
  task automatic run_txn(input int id, input vec_t v, input bit rnd);
    int a, nsup;
    bit legal;
    logic [7:0] pl[$], exp[$];
    legal = (v.len >= 1) && (v.len <= MAX_LEN);
    nsup = legal ? int'(v.len) : 0;
    start_txn(v.w, v.addr, v.len, nsup, v.d0, rnd, v.soff, v.slen, v.gap, a, pl);
    if (legal) begin
      exp.push_back({~v.w, 1'b0, v.addr});
      exp.push_back(v.len);
      if (v.w) foreach (pl[i]) exp.push_back(pl[i]);
    end
    wait_done(400);
    chk("done_count", done_cnt, 1);
    chk("error", int'(done_err), int'(v.exp_err));
    chk("tx_count", txq.size(), v.exp_ntx);
    for (int i = 0; i < exp.size() && i < txq.size(); i++) chk("tx_byte", txq[i], exp[i]);
    chk("rd_count", rdq.size(), (v.w || !legal) ? 0 : int'(v.len));
    if (!v.w) for (int i = 0; i < pl.size() && i < rdq.size(); i++) chk("rd_byte", rdq[i], pl[i]);
    chk("strobe_rules", viol, 0);
    chk("ready_at_done", int'(done_rdy), int'(!legal));
    chk("ready_after_done", int'(rdy_after), 1);
    if (v.tchk && txc.size() > 0) begin
      chk("hdr_cycle", txc[0] - a, 1);
      chk("last_data_cycle", txc[txc.size()-1] - a, int'(v.len) + 2);
      chk("done_cycle", done_cyc - a, int'(v.len) + 3);
    end
    $display("txn %0d: %s addr=0x%02h len=%0d tx=%0d rd=%0d err=%0d done@+%0d",
             id, v.w ? "WR" : "RD", v.addr, v.len, txq.size(), rdq.size(), done_err, done_cyc - a);
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    int a;
    logic [7:0] pl[$];
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 6'd0; req_len = 8'd0;
    wr_valid = 1'b0; wr_data = 8'd0; tx_full = 1'b0; rx_byte = 8'd0; rx_empty = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    chk("rst_tx_wr", int'(tx_wr), 0);
    chk("rst_rx_rd", int'(rx_rd), 0);
    reset = 1'b0;

    //            w     addr   len    d0     soff slen gap  err  ntx tchk
    vecs[0] = '{1'b1, 6'h01, 8'd1, 8'h5A, 0, 0, 1'b0, 1'b0, 3, 1'b1};
    vecs[1] = '{1'b0, 6'h04, 8'd4, 8'h11, 0, 0, 1'b0, 1'b0, 2, 1'b0};
    vecs[2] = '{1'b1, 6'h2A, 8'd3, 8'hA0, 4, 5, 1'b0, 1'b0, 5, 1'b0};
    vecs[3] = '{1'b1, 6'h03, 8'd0, 8'h00, 0, 0, 1'b0, 1'b1, 0, 1'b0};
    vecs[4] = '{1'b0, 6'h09, 8'd9, 8'h00, 0, 0, 1'b0, 1'b1, 0, 1'b0};
    vecs[5] = '{1'b1, 6'h3F, 8'd8, 8'h01, 0, 0, 1'b0, 1'b0, 10, 1'b1};
    vecs[6] = '{1'b0, 6'h00, 8'd1, 8'hE7, 0, 0, 1'b0, 1'b0, 2, 1'b0};
    vecs[7] = '{1'b1, 6'h10, 8'd2, 8'h33, 0, 3, 1'b0, 1'b0, 4, 1'b0};
    for (int i = 0; i < 8; i++) run_txn(i, vecs[i], 1'b0);

    // Randomized transactions; expectations from the protocol rules
    for (int i = 0; i < 24; i++) begin
      rv.w = 1'($urandom);
      rv.addr = 6'($urandom);
      rv.len = 8'($urandom_range(0, MAX_LEN + 1));
      rv.d0 = 8'h00;
      rv.soff = $urandom_range(0, 8);
      rv.slen = $urandom_range(0, 4);
      rv.gap = 1'($urandom);
      rv.exp_err = !((rv.len >= 1) && (rv.len <= MAX_LEN));
      rv.exp_ntx = rv.exp_err ? 0 : (rv.w ? int'(rv.len) + 2 : 2);
      rv.tchk = 1'b0;
      run_txn(100 + i, rv, 1'b1);
    end

    // Reset in the middle of a read after two of four bytes
    start_txn(1'b0, 6'h05, 8'd4, 2, 8'hC1, 1'b0, 0, 0, 1'b0, a, pl);
    for (int k = 0; k < 100 && rdq.size() < 2; k++) @(negedge clk);
    chk("mid_rd_count", rdq.size(), 2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_tx_wr", int'(tx_wr), 0);
    chk("mid_rst_rx_rd", int'(rx_rd), 0);
    chk("mid_rst_wr_ready", int'(wr_ready), 0);
    chk("mid_rst_rd_valid", int'(rd_valid), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_req_ready", int'(req_ready), 1);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    $display("txn reset: RD addr=0x05 len=4 abandoned after %0d bytes", rdq.size());

    // Read of two bytes with only one ever supplied
    start_txn(1'b0, 6'h07, 8'd2, 1, 8'h6B, 1'b0, 0, 0, 1'b0, a, pl);
`ifdef CMDMASTER_TIMEOUT_EN
    wait_done(80);
    chk("tmo_done", done_cnt, 1);
    chk("tmo_error", int'(done_err), 1);
    chk("tmo_rd_count", rdq.size(), 1);
    chk("tmo_delay_ok", int'((done_cyc - last_pop_cyc >= TMO) && (done_cyc - last_pop_cyc <= TMO + 4)), 1);
`else
    repeat (80) @(negedge clk);
    chk("starve_no_done", done_cnt, 0);
    chk("starve_busy", int'(req_ready), 0);
    chk("starve_rd_count", rdq.size(), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
`endif
    $display("txn starve: RD addr=0x07 len=2 done=%0d rd=%0d", done_cnt, rdq.size());

    chk("rx_underflow", underflow, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=expired required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
